gpr_wr_arb: RTL
===============

Name: gpr_wr_arb

Overview:
- Round-robin arbiter that shares the single GPR write port (Sw/Sc/Sin) between NREQ writeback requesters, e.g. ALU, load unit and move unit.
- Sits directly in front of the gpr register file. Its registered outputs connect straight to the gpr write inputs.
- Also keeps a saturating contention counter for performance debug.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 5, register address width (32 registers)
- DW, 32, data width
- DROP_R0, 0, when 1 a write to register 0 is accepted but suppressed (Sw stays 0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable; 0 = stall, no grants
- req  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed target addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot acceptance, combinational, valid in the accepting cycle
- Sw  out  1  registered GPR write enable
- Sc  out  AW  registered GPR write address
- Sin  out  DW  registered GPR write data
- conflict_cnt  out  16  saturating count of contended cycles

Behaviour:
- Reset: Sw=0, Sc=0, Sin=0, ptr=0, conflict_cnt=0, asserted asynchronously. gnt=0 while rst_n=0.
- Handshake: requester i raises req[i] with addr/data stable and holds all three until it samples gnt[i]=1 at a rising edge. It may then drop req or present the next write in the following cycle.
- Arbitration, combinational: if en=1 and |req, search indices ptr, ptr+1, ... (mod NREQ). The first set req wins and gnt is one-hot on the winner. Otherwise gnt=0.
- On the edge where gnt[w]=1:
  - ptr <= (w+1) mod NREQ
  - Sc <= addr[w], Sin <= data[w]
  - Sw <= 1, except Sw <= 0 if DROP_R0=1 and addr[w]=0. That request is still granted.
- On an edge with no grant: Sw <= 0; Sc/Sin hold; ptr holds.
- Latency: grant at edge k, outputs valid after edge k, GPR captures at edge k+1. At most one write per cycle, so back-to-back grants give continuous Sw=1.
- Fairness: any held request is granted within NREQ cycles while en=1.
- en=0: no grants, Sw <= 0 next edge, ptr frozen. Requests stay pending and nothing is lost.
- conflict_cnt: +1 on each edge where en=1 and popcount(req)>=2. Saturates at 16'hFFFF with no wrap.
- Single requester: granted every cycle it requests. ptr still advances past it.
- Reset mid-operation: an in-flight write is dropped (Sw forced 0 immediately). Requesters must re-present after rst_n deasserts.
- Same address from two requesters in one cycle: no merging. Both are written in grant order, so the later grant's data wins in the GPR.
- Invalid NREQ outside 2..8 is an elaboration error.

Decomposition:
- Shared package gpr_pkg holds GPR_AW=5, GPR_DW=32, GPR_NREGS=32 and the CONFLICT_W=16 constant. gpr and gpr_wr_arb both use it.
- One natural sub-module: rr_pick, a parameterised combinational round-robin one-hot picker (req, ptr -> gnt, winner index). It is reusable for a future read-port arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with Sw=1 -> Sw, Sc, Sin, conflict_cnt read 0 immediately; gnt=0 until release.
- Single request: req=3'b001, addr=5, data=32'hAAAA5555 -> gnt=001 that cycle; next cycle Sw=1, Sc=5, Sin=32'hAAAA5555; gpr reg 5 reads 32'hAAAA5555 via Sa=5.
- Contention: all three req held for 6 cycles from ptr=0 with addr 1/2/3 and data 32'h11/32'h22/32'h33 -> grant order 0,1,2,0,1,2; Sw continuously 1; conflict_cnt=6.
- Same address: req0 and req1 both addr 10, data 32'h12345678 and 32'hDEADBEEF -> both granted in order; reg 10 finally 32'hDEADBEEF.
- Stall and DROP_R0: en=0 for 3 cycles with req=001 -> gnt=0, Sw=0, ptr unchanged, then granted on en=1. With DROP_R0=1, addr 0 data 32'hDEADBEEF -> gnt pulses, Sw stays 0, reg 0 unchanged.
- Saturation: force 70000 contended cycles -> conflict_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants for the general-purpose register file and its write-port arbiter.
package gpr_pkg;
    localparam int GPR_AW     = 5;
    localparam int GPR_DW     = 32;
    localparam int GPR_NREGS  = 32;
    localparam int CONFLICT_W = 16;
endpackage

// File: rtl/gpr_wr_arb_rr_pick.sv
// Combinational round-robin picker: searches req starting at ptr, returns one-hot gnt and the winner index.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] win
);
    logic [PW-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest requester is the last to overwrite.
    always_comb begin
        gnt = '0;
        win = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end
endmodule

// File: rtl/gpr_wr_arb.sv
// Round-robin arbiter sharing the single GPR write port (Sw/Sc/Sin) among NREQ writeback sources.
module gpr_wr_arb
    import gpr_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AW      = GPR_AW,
    parameter int DW      = GPR_DW,
    parameter int DROP_R0 = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]    req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  Sw,
    output logic [AW-1:0]         Sc,
    output logic [DW-1:0]         Sin,
    output logic [CONFLICT_W-1:0] conflict_cnt
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("gpr_wr_arb: NREQ must be in 2..8");
    end

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] pick_gnt;
    logic [NREQ-1:0] req_eff;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            any_gnt;
    logic            drop;
    logic            contended;

    assign req_eff = en ? req : '0;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (req_eff),
        .ptr (ptr),
        .gnt (pick_gnt),
        .win (win)
    );

    // Grant is forced low during reset so no requester believes it was accepted.
    assign gnt       = rst_n ? pick_gnt : '0;
    assign any_gnt   = |pick_gnt;
    assign sel_addr  = req_addr[int'(win)*AW +: AW];
    assign sel_data  = req_data[int'(win)*DW +: DW];
    assign drop      = (DROP_R0 != 0) && (sel_addr == '0);
    assign contended = en && ($countones(req) >= 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            Sw  <= 1'b0;
            Sc  <= '0;
            Sin <= '0;
        end else if (any_gnt) begin
            ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            Sw  <= !drop;
            Sc  <= sel_addr;
            Sin <= sel_data;
        end else begin
            Sw  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (contended && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule
